tcdm_cfi_responder: RTL and testbench
=====================================

TCDM_CFI_RESPONDER -- requirements
Module: tcdm_cfi_responder

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DATA_WIDTH, 40, CFI data width (32 data + 8 tag bits).
- BE_WIDTH, DATA_WIDTH/8 = 5, byte enables.
- MEM_ADDR_WIDTH, 14, SRAM word-address width.
- BASE_ADDR, 32'h1C00_0000, first byte address served.
- MAX_WAIT, 7, largest supported wait-state count.
REQ-002 Ports (name, direction, width, meaning):
- clk_i, in, 1, single clock; all logic is rising-edge.
- rst_i, in, 1, asynchronous active-high reset.
- tcdm_req_i, in, 1, request.
- tcdm_add_i, in, 32, byte address.
- tcdm_wen_i, in, 1, 1 = read, 0 = write.
- tcdm_wdata_i, in, DATA_WIDTH, write data.
- tcdm_be_i, in, BE_WIDTH, byte enables.
- tcdm_gnt_o, out, 1, grant.
- tcdm_r_valid_o, out, 1, response valid.
- tcdm_r_rdata_o, out, DATA_WIDTH, read data.
- tcdm_r_opc_o, out, 1, error flag.
- wait_states_i, in, $clog2(MAX_WAIT+1), grant wait states.
- mem_req_o, out, 1, SRAM chip enable.
- mem_we_o, out, 1, SRAM write.
- mem_addr_o, out, MEM_ADDR_WIDTH, SRAM word address.
- mem_wdata_o, out, DATA_WIDTH, SRAM write data.
- mem_be_o, out, BE_WIDTH, SRAM byte mask.
- mem_rdata_i, in, DATA_WIDTH, SRAM read data (1-cycle latency).

Function
REQ-003 A transaction is accepted in the cycle where tcdm_req_i and tcdm_gnt_o are both 1.
REQ-004 FSM states IDLE and STALL:
- IDLE with req and wait = 0: gnt = 1 combinationally, stay in IDLE.
- IDLE with req and wait = N > 0: gnt = 0, load counter with N-1, go to STALL.
- STALL with counter > 0: gnt = 0, decrement.
- STALL with counter = 0: gnt = req, return to IDLE.
REQ-005 wait_states_i is sampled only on the IDLE->STALL transition; changes during STALL are ignored.
REQ-006 If req drops during STALL (protocol violation): go to IDLE, no grant, no SRAM access.
REQ-007 In-range address: (add - BASE_ADDR) >> 2 < 2**MEM_ADDR_WIDTH. Otherwise the address is out of range.
REQ-008 On an in-range grant, in the same cycle:
- mem_req_o = 1 and mem_we_o = ~tcdm_wen_i.
- mem_addr_o = (add - BASE_ADDR)[MEM_ADDR_WIDTH+1:2]; the 2 LSBs are ignored.
- mem_wdata_o = tcdm_wdata_i and mem_be_o = tcdm_be_i.
REQ-009 When there is no in-range grant, mem_req_o = 0 and mem_we_o = 0. mem_addr_o, mem_wdata_o and mem_be_o are don't-care.
REQ-010 r_valid is asserted exactly one cycle after every grant, for exactly one cycle.
REQ-011 Response data and error flag:
- Read: r_rdata = mem_rdata_i.
- Write: r_rdata = 0.
- Out-of-range access: r_opc = 1 and r_rdata = 0, with no SRAM access. Otherwise r_opc = 0.
REQ-012 r_rdata and r_opc are 0 whenever r_valid = 0.
REQ-013 Back-to-back operation with wait = 0: one grant per cycle, so r_valid for transaction k coincides with the grant for k+1. Full throughput, no bubbles.
REQ-014 With wait = N > 0, each transaction takes N+1 cycles from first req to grant. A new request is evaluated in the cycle after the grant.
REQ-015 Address wrap: the subtraction is modulo 2^32, so addresses below BASE_ADDR are out of range.

Reset
REQ-016 While rst_i = 1:
- FSM = IDLE and counter = 0.
- gnt, r_valid, r_opc, r_rdata, mem_req and mem_we are all 0.
REQ-017 Reset asserted mid-STALL or with a response pending drops that response. No r_valid appears after reset deasserts until a new grant is made.
REQ-018 The first grant is possible in the first rising edge after rst_i falls.

Structure
REQ-019 A shared package tcdm_cfi_pkg holds:
- the FSM state enum;
- the CFI_DATA_WIDTH and CFI_BE_WIDTH constants;
- a response struct {valid, opc, rdata}.
REQ-020 The wait-state counter is one sub-module, tcdm_wait_counter: load, decrement, zero flag. Everything else stays in tcdm_cfi_responder.

Verification
REQ-021 Single read, wait = 0: BASE+0x10 at cycle 0 -> gnt at cycle 0, mem_addr = 4, r_valid at cycle 1, rdata = the SRAM word, opc = 0.
REQ-022 Write followed by read, wait = 0: write 40'hAB_DEADBEEF with be = 5'b11111 to BASE+0x8, then read BASE+0x8 -> two consecutive grants, read rdata = 40'hAB_DEADBEEF.
REQ-023 Wait states: wait = 3 with a steady read -> gnt in cycle 3 (not cycles 0-2), r_valid in cycle 4. Changing wait to 0 at cycle 1 has no effect.
REQ-024 Out of range: read BASE-4 and BASE + (2**MEM_ADDR_WIDTH)*4 -> each is granted, mem_req = 0, r_valid one cycle later with opc = 1 and rdata = 0.
REQ-025 Burst of 8 reads, wait = 0 -> 8 consecutive grants, 8 consecutive r_valid cycles, each offset by 1 cycle and in order.
REQ-026 Reset and protocol violation:
- rst_i pulse in the cycle after a grant -> no r_valid appears.
- req dropped in STALL -> no gnt and no mem_req.

Source files
------------

// File: rtl/tcdm_cfi_pkg.sv
// Shared types for the TCDM CFI responder: grant FSM states, CFI widths
// and the response bundle presented on the r_* channel.
package tcdm_cfi_pkg;

    localparam int CFI_DATA_WIDTH = 40;
    localparam int CFI_BE_WIDTH   = CFI_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } cfi_state_e;

    typedef struct packed {
        logic                      valid;
        logic                      opc;
        logic [CFI_DATA_WIDTH-1:0] rdata;
    } cfi_resp_t;

endpackage

// File: rtl/tcdm_wait_counter.sv
// Wait-state down-counter: loads a start value, decrements to zero and
// flags when zero has been reached.
module tcdm_wait_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Counter register: load has priority, decrement saturates at zero.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tcdm_cfi_responder.sv
// TCDM slave with CFI tag bits: programmable grant wait states, SRAM
// port with one-cycle read latency, and out-of-range error responses.
module tcdm_cfi_responder
    import tcdm_cfi_pkg::*;
#(
    parameter int          DATA_WIDTH     = 40,
    parameter int          BE_WIDTH       = DATA_WIDTH / 8,
    parameter int          MEM_ADDR_WIDTH = 14,
    parameter logic [31:0] BASE_ADDR      = 32'h1C00_0000,
    parameter int          MAX_WAIT       = 7,
    parameter int          WS_W           = $clog2(MAX_WAIT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      tcdm_req_i,
    input  logic [31:0]               tcdm_add_i,
    input  logic                      tcdm_wen_i,
    input  logic [DATA_WIDTH-1:0]     tcdm_wdata_i,
    input  logic [BE_WIDTH-1:0]       tcdm_be_i,
    output logic                      tcdm_gnt_o,
    output logic                      tcdm_r_valid_o,
    output logic [DATA_WIDTH-1:0]     tcdm_r_rdata_o,
    output logic                      tcdm_r_opc_o,
    input  logic [WS_W-1:0]           wait_states_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    output logic [BE_WIDTH-1:0]       mem_be_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam logic [31:0] NUM_WORDS = 32'd1 << MEM_ADDR_WIDTH;

    cfi_state_e  state_q, state_d;
    logic        gnt_s, load_s, dec_s, cnt_zero_s;
    logic [31:0] offset_s;
    logic        in_range_s;
    logic        valid_q, opc_q, rd_q;
    cfi_resp_t   resp_s;

    // Modulo-2^32 subtraction makes addresses below the base wrap out of range.
    assign offset_s   = tcdm_add_i - BASE_ADDR;
    assign in_range_s = ((offset_s >> 2) < NUM_WORDS);

    tcdm_wait_counter #(
        .WIDTH (WS_W)
    ) u_wait_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load_s),
        .load_val_i (wait_states_i - {{(WS_W-1){1'b0}}, 1'b1}),
        .dec_i      (dec_s),
        .zero_o     (cnt_zero_s)
    );

    // Grant / stall decision; a request dropped mid-stall is abandoned.
    always_comb begin
        gnt_s   = 1'b0;
        load_s  = 1'b0;
        dec_s   = 1'b0;
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tcdm_req_i && (wait_states_i == '0)) begin
                    gnt_s = 1'b1;
                end else if (tcdm_req_i) begin
                    load_s  = 1'b1;
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STALL: begin
                if (!tcdm_req_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_zero_s) begin
                    gnt_s   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    dec_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tcdm_gnt_o  = gnt_s & ~rst_i;
    assign mem_req_o   = tcdm_gnt_o & in_range_s;
    assign mem_we_o    = mem_req_o & ~tcdm_wen_i;
    assign mem_addr_o  = offset_s[MEM_ADDR_WIDTH+1:2];
    assign mem_wdata_o = tcdm_wdata_i;
    assign mem_be_o    = tcdm_be_i;

    // FSM state and response flags for the transaction granted last cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            opc_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= tcdm_gnt_o;
            opc_q   <= tcdm_gnt_o & ~in_range_s;
            rd_q    <= tcdm_gnt_o & in_range_s & tcdm_wen_i;
        end
    end

    // Read data arrives from the SRAM in the response cycle itself.
    assign resp_s.valid = valid_q;
    assign resp_s.opc   = opc_q;
    assign resp_s.rdata = rd_q ? mem_rdata_i : '0;

    assign tcdm_r_valid_o = resp_s.valid;
    assign tcdm_r_opc_o   = resp_s.opc;
    assign tcdm_r_rdata_o = resp_s.rdata;

endmodule

// File: tb/tb_tcdm_cfi_responder.sv
// Scoreboard bench for tcdm_cfi_responder with a behavioural SRAM.
module tb_tcdm_cfi_responder;

    localparam logic [31:0] BASE = 32'h1C00_0000;

    typedef struct packed {
        logic        opc;
        logic [39:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] add = 32'h0;
    logic        wen = 1'b1;
    logic [39:0] wdata = 40'h0;
    logic [4:0]  be = 5'h0;
    logic [2:0]  ws = 3'd0;
    logic        gnt, r_valid, r_opc, mem_req, mem_we;
    logic [39:0] r_rdata, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;
    logic [4:0]  mem_be;

    logic [39:0] sram [0:16383];
    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    tcdm_cfi_responder dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .tcdm_req_i     (req),
        .tcdm_add_i     (add),
        .tcdm_wen_i     (wen),
        .tcdm_wdata_i   (wdata),
        .tcdm_be_i      (be),
        .tcdm_gnt_o     (gnt),
        .tcdm_r_valid_o (r_valid),
        .tcdm_r_rdata_o (r_rdata),
        .tcdm_r_opc_o   (r_opc),
        .wait_states_i  (ws),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_be_o       (mem_be),
        .mem_rdata_i    (mem_rdata)
    );

    // Byte-masked SRAM with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 5; b++)
                    if (mem_be[b]) sram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    function automatic logic [39:0] pat(input int i);
        logic [31:0] iw;
        iw = i;
        return {iw[7:0], 32'h5A00_0000 | iw};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (r_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_r_valid", 64'd1, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_opc", {63'd0, r_opc}, {63'd0, e.opc});
                        chk("resp_rdata", {24'd0, r_rdata}, {24'd0, e.rdata});
                    end
                end else begin
                    chk("idle_resp_zero", {23'd0, r_opc, r_rdata}, 64'd0);
                end
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] a, input logic w,
                         input logic [39:0] wd, input logic [4:0] b, input logic [2:0] wst,
                         input int exp_stall, input bit exp_in, input logic [13:0] exp_maddr,
                         input bit push, input logic exp_opc, input logic [39:0] exp_rd,
                         input bit chg_wait, input bit exp_prev_valid);
        int  c;
        bit  got;
        exp_t e;
        c = 0;
        got = 1'b0;
        req = 1'b1; add = a; wen = w; wdata = wd; be = b; ws = wst;
        while (!got && c <= exp_stall + 4) begin
            @(negedge clk);
            if (gnt) begin
                got = 1'b1;
            end else begin
                chk({nm, "_stall_no_memreq"}, {63'd0, mem_req}, 64'd0);
                c++;
                @(posedge clk); #1;
                if (chg_wait && c == 1) ws = 3'd0;
            end
        end
        chk({nm, "_grant_cycle"}, got ? 64'(c) : 64'hFFFF, 64'(exp_stall));
        if (got) begin
            chk({nm, "_mem_req"}, {63'd0, mem_req}, {63'd0, exp_in});
            if (exp_in) begin
                chk({nm, "_mem_we"}, {63'd0, mem_we}, {63'd0, ~w});
                chk({nm, "_mem_addr"}, {50'd0, mem_addr}, {50'd0, exp_maddr});
                if (!w) chk({nm, "_mem_wdata_be"}, {19'd0, mem_be, mem_wdata}, {19'd0, b, wd});
            end else begin
                chk({nm, "_mem_we_oor"}, {63'd0, mem_we}, 64'd0);
            end
            if (exp_prev_valid) chk({nm, "_b2b_prev_valid"}, {63'd0, r_valid}, 64'd1);
            if (push) begin
                e.opc = exp_opc;
                e.rdata = exp_rd;
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
        end else begin
            req = 1'b0;
        end
    endtask

    task automatic idle(input bit exp_valid);
        req = 1'b0;
        @(negedge clk);
        chk("idle_r_valid", {63'd0, r_valid}, {63'd0, exp_valid});
        chk("idle_no_gnt", {63'd0, gnt}, 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16384; i++) sram[i] = pat(i);
        mem_rdata = 40'h0;
        // Reset holds every output low even with a live zero-wait request.
        req = 1'b1; add = BASE; wen = 1'b1; ws = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", {63'd0, gnt}, 64'd0);
        chk("rst_mem_req_we", {62'd0, mem_req, mem_we}, 64'd0);
        chk("rst_resp", {22'd0, r_valid, r_opc, r_rdata}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req = 1'b0;
        mon_en = 1'b1;

        issue("rd10", BASE + 32'h10, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'd4, 1'b1, 1'b0, 40'h04_5A000004, 1'b0, 1'b0);
        idle(1'b1);

        issue("wr08", BASE + 32'h8, 1'b0, 40'hAB_DEADBEEF, 5'b11111, 3'd0, 0, 1'b1, 14'd2, 1'b1, 1'b0, 40'h0, 1'b0, 1'b0);
        issue("rd08", BASE + 32'h8, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'd2, 1'b1, 1'b0, 40'hAB_DEADBEEF, 1'b0, 1'b1);
        idle(1'b1);

        issue("wr20p", BASE + 32'h20, 1'b0, 40'h11_22334455, 5'b00101, 3'd0, 0, 1'b1, 14'd8, 1'b1, 1'b0, 40'h0, 1'b0, 1'b0);
        issue("rd20p", BASE + 32'h22, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'd8, 1'b1, 1'b0, 40'h08_5A330055, 1'b0, 1'b1);
        idle(1'b1);

        issue("ws3", BASE + 32'h10, 1'b1, 40'h0, 5'h1F, 3'd3, 3, 1'b1, 14'd4, 1'b1, 1'b0, 40'h04_5A000004, 1'b1, 1'b0);
        idle(1'b1);

        issue("oor_low", BASE - 32'd4, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b0, 14'd0, 1'b1, 1'b1, 40'h0, 1'b0, 1'b0);
        issue("oor_high", BASE + 32'h0001_0000, 1'b0, 40'h12_34567890, 5'h1F, 3'd0, 0, 1'b0, 14'd0, 1'b1, 1'b1, 40'h0, 1'b0, 1'b1);
        idle(1'b1);

        for (int i = 0; i < 8; i++)
            issue("burst", BASE + 32'h40 + 32'(4 * i), 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'(16 + i),
                  1'b1, 1'b0, pat(16 + i), 1'b0, i != 0);
        idle(1'b1);

        // Reset in the response cycle discards the pending response.
        issue("rst_drop", BASE + 32'h40, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'd16, 1'b0, 1'b0, 40'h0, 1'b0, 1'b0);
        rst = 1'b1;
        req = 1'b0;
        @(negedge clk);
        chk("rst_drop_valid", {63'd0, r_valid}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) idle(1'b0);

        // Request withdrawn during the stall: no grant, no SRAM access.
        req = 1'b1; add = BASE + 32'h10; wen = 1'b1; ws = 3'd3;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("viol_gnt", {63'd0, gnt}, 64'd0);
            chk("viol_mem_req", {63'd0, mem_req}, 64'd0);
            @(posedge clk); #1;
        end
        idle(1'b0);
        issue("after_viol", BASE + 32'h14, 1'b1, 40'h0, 5'h1F, 3'd0, 0, 1'b1, 14'd5, 1'b1, 1'b0, 40'h05_5A000005, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
